// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the MEM stage and a byte-laned, big-endian data RAM.
// Define MEM_ACCESS_CTRL_ALIGN_CHK_EN to flag misaligned half/word accesses instead of forcing alignment.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [31:0]       ram_data_o,
    input  logic [31:0]       ram_data_i
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic is_store(input logic [2:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    // Loads read the whole word; stores enable only the lanes they write.
    function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] ofs);
        case (op)
            OP_SB:   lane_sel = 4'b1000 >> ofs;
            OP_SH:   lane_sel = ofs[1] ? 4'b0011 : 4'b1100;
            OP_SW:   lane_sel = 4'b1111;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
        case (op)
            OP_SB:   store_data = {4{wd[7:0]}};
            OP_SH:   store_data = {2{wd[15:0]}};
            OP_SW:   store_data = wd;
            default: store_data = 32'd0;
        endcase
    endfunction

    // Big-endian: offset 0 is the most significant byte of the word.
    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] ofs,
                                                 input logic [31:0] d);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = d >> {~ofs, 3'b000};
        b       = shifted[7:0];
        h       = ofs[1] ? d[15:0] : d[31:16];
        case (op)
            OP_LB:   load_extract = {{24{b[7]}}, b};
            OP_LBU:  load_extract = {24'd0, b};
            OP_LH:   load_extract = {{16{h[15]}}, h};
            OP_LHU:  load_extract = {16'd0, h};
            OP_LW:   load_extract = d;
            default: load_extract = 32'd0;
        endcase
    endfunction

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic [2:0]         op_q;
    logic [1:0]         ofs_q;
    logic               ram_ce_q;
    logic               ram_we_q;
    logic [ADDR_W-1:0]  ram_addr_q;
    logic [3:0]         ram_sel_q;
    logic [31:0]        ram_data_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic               misalign_s;

`ifdef MEM_ACCESS_CTRL_ALIGN_CHK_EN
    // Half accesses need an even address, word accesses a word-aligned one.
    always_comb begin
        misalign_s = 1'b0;
        case (req_op)
            OP_LH, OP_LHU, OP_SH: misalign_s = req_addr[0];
            OP_LW, OP_SW:         misalign_s = |req_addr[1:0];
            default:              misalign_s = 1'b0;
        endcase
    end
`else
    assign misalign_s = 1'b0;
`endif

    // Request/access/response sequencer with all RAM and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            op_q         <= 3'd0;
            ofs_q        <= 2'd0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_sel_q    <= 4'd0;
            ram_data_q   <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        op_q  <= req_op;
                        ofs_q <= req_addr[1:0];
                        if (misalign_s) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                            state_q      <= ST_RESP;
                        end else begin
                            ram_ce_q   <= 1'b1;
                            ram_we_q   <= is_store(req_op) && (WAIT_INIT == 4'd0);
                            ram_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            ram_sel_q  <= lane_sel(req_op, req_addr[1:0]);
                            ram_data_q <= store_data(req_op, req_wdata);
                            cnt_q      <= WAIT_INIT;
                            state_q    <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        ram_ce_q     <= 1'b0;
                        ram_we_q     <= 1'b0;
                        ram_addr_q   <= '0;
                        ram_sel_q    <= 4'd0;
                        ram_data_q   <= 32'd0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= is_store(op_q) ? 32'd0 : load_extract(op_q, ofs_q, ram_data_i);
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q    <= cnt_q - 4'd1;
                        ram_we_q <= is_store(op_q) && (cnt_q == 4'd1);
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    ram_ce_q     <= 1'b0;
                    ram_we_q     <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_ce_o   = ram_ce_q;
    assign ram_we_o   = ram_we_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_sel_o  = ram_sel_q;
    assign ram_data_o = ram_data_q;

endmodule
